// File: rtl/frame_pos_sched_if.sv
// Request-side bundle for frame_pos_sched: per-requester valid/ready
// handshake plus the x/y position carried by each requester.
interface frame_pos_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [11:0] req_xpos0;
    logic [11:0] req_ypos0;
    logic [11:0] req_xpos1;
    logic [11:0] req_ypos1;

    // Position source side (mouse / UART logic)
    modport master (
        output req_valid, req_xpos0, req_ypos0, req_xpos1, req_ypos1,
        input  req_ready
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_xpos0, req_ypos0, req_xpos1, req_ypos1,
        output req_ready
    );
endinterface

// File: rtl/frame_pos_sched.sv
// Frame-synchronised position scheduler. Position updates from two
// requesters (0 = local mouse, 1 = remote player) are held in shadow slots
// and committed to the draw-side outputs once per frame, starting at the
// rising edge of vblnk: requester 0 one cycle, requester 1 the next.
// Optional feature macro: LAST_WINS_EN -- ready is always high outside
// reset and a newer update overwrites a pending one.
module frame_pos_sched #(
    parameter logic [11:0] X_MAX = 12'd799,
    parameter logic [11:0] Y_MAX = 12'd599
) (
    input  logic                    clk40MHz,
    input  logic                    rst,
    input  logic                    vblnk,
    frame_pos_sched_if.slave        req,
    output logic [11:0]             xpos0_out,
    output logic [11:0]             ypos0_out,
    output logic [11:0]             xpos1_out,
    output logic [11:0]             ypos1_out,
    output logic [1:0]              commit_pulse,
    output logic [15:0]             frame_cnt
);

    typedef enum logic [1:0] {IDLE, COMMIT0, COMMIT1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_vblnk_d;
    logic                   w_edge;
    logic [1:0]             w_commit;
    logic                   w_frame_done;
    logic [1:0]             w_accept;
    logic [1:0]             r_pending;
    logic [1:0][11:0]       r_shadow_x;
    logic [1:0][11:0]       r_shadow_y;
    logic [1:0][11:0]       r_out_x;
    logic [1:0][11:0]       r_out_y;
    logic [1:0][11:0]       w_req_x;
    logic [1:0][11:0]       w_req_y;
    logic [1:0]             r_pulse;
    logic [15:0]            r_frame_cnt;

    function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign w_req_x  = {req.req_xpos1, req.req_xpos0};
    assign w_req_y  = {req.req_ypos1, req.req_ypos0};
    assign w_edge   = vblnk && !r_vblnk_d;

`ifdef LAST_WINS_EN
    assign req.req_ready = rst ? 2'b00 : 2'b11;
`else
    assign req.req_ready = rst ? 2'b00 : ~r_pending;
`endif

    assign w_accept = req.req_valid & req.req_ready;

    // State register and vblnk delay for edge detection
    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            r_state   <= IDLE;
            r_vblnk_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vblnk_d <= vblnk;
        end
    end

    // Next-state and per-requester commit decode; edges are ignored outside IDLE
    always_comb begin
        w_state_nxt  = r_state;
        w_commit     = '0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) w_state_nxt = COMMIT0;
            end
            COMMIT0: begin
                w_commit[0] = r_pending[0];
                w_state_nxt = COMMIT1;
            end
            COMMIT1: begin
                w_commit[1]  = r_pending[1];
                w_frame_done = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shadow capture, commit of clamped shadow to outputs, pending and frame count.
    // A commit reads the shadow before any same-cycle accept overwrites it, and
    // a same-cycle accept keeps pending set so the new value goes out next frame.
    always_ff @(posedge clk40MHz) begin
        if (rst) begin
            r_pending   <= '0;
            r_shadow_x  <= '0;
            r_shadow_y  <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_pulse     <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_pulse <= w_commit;
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_commit[i]) begin
                    r_out_x[i] <= clamp(r_shadow_x[i], X_MAX);
                    r_out_y[i] <= clamp(r_shadow_y[i], Y_MAX);
                end
                if (w_accept[i]) begin
                    r_shadow_x[i] <= w_req_x[i];
                    r_shadow_y[i] <= w_req_y[i];
                end
                r_pending[i] <= w_accept[i] | (r_pending[i] & ~w_commit[i]);
            end
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign xpos0_out    = r_out_x[0];
    assign ypos0_out    = r_out_y[0];
    assign xpos1_out    = r_out_x[1];
    assign ypos1_out    = r_out_y[1];
    assign commit_pulse = r_pulse;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_frame_pos_sched.sv
// Bench for frame_pos_sched: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a timestamp-based
// behavioural model of the commit schedule.
module tb_frame_pos_sched;

`ifdef LAST_WINS_EN
    localparam bit LW = 1'b1;
`else
    localparam bit LW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk;
    logic [11:0] xpos0_out, ypos0_out, xpos1_out, ypos1_out;
    logic [1:0]  commit_pulse;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    frame_pos_sched_if u_if ();

    frame_pos_sched #(.X_MAX(12'd799), .Y_MAX(12'd599)) dut (
        .clk40MHz     (clk),
        .rst          (rst),
        .vblnk        (vblnk),
        .req          (u_if),
        .xpos0_out    (xpos0_out),
        .ypos0_out    (ypos0_out),
        .xpos1_out    (xpos1_out),
        .ypos1_out    (ypos1_out),
        .commit_pulse (commit_pulse),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_live = 1'b0;
    logic [11:0] m_x [2];
    logic [11:0] m_y [2];
    logic [11:0] m_sx [2];
    logic [11:0] m_sy [2];
    logic [1:0]  m_pend;
    logic [1:0]  m_pulse;
    logic [15:0] m_cnt;
    bit          m_prev;
    bit          m_busy;
    int          m_e0;

    function automatic logic [1:0] model_ready();
        if (rst) return 2'b00;
        return LW ? 2'b11 : ~m_pend;
    endfunction

    function automatic logic [11:0] lim(input logic [11:0] v, input logic [11:0] l);
        return (v > l) ? l : v;
    endfunction

    task automatic model_commit(input int i);
        if (m_pend[i]) begin
            m_x[i]     = lim(m_sx[i], 12'd799);
            m_y[i]     = lim(m_sy[i], 12'd599);
            m_pulse[i] = 1'b1;
            m_pend[i]  = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        logic [1:0] rdy;
        logic [1:0] acc;
        bit         frame_edge;
        cyc++;
        rdy = model_ready();
        if (rst) begin
            m_live = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_x[i] = '0; m_y[i] = '0; m_sx[i] = '0; m_sy[i] = '0;
            end
            m_pend = '0; m_pulse = '0; m_cnt = '0;
            m_prev = 1'b0; m_busy = 1'b0; m_e0 = 0;
        end else begin
            m_pulse    = '0;
            frame_edge = vblnk && !m_prev && !m_busy;
            if (m_busy && cyc == m_e0) model_commit(0);
            if (m_busy && cyc == m_e0 + 1) begin
                model_commit(1);
                m_cnt  = m_cnt + 16'd1;
                m_busy = 1'b0;
            end
            acc = u_if.req_valid & rdy;
            if (acc[0]) begin m_sx[0] = u_if.req_xpos0; m_sy[0] = u_if.req_ypos0; m_pend[0] = 1'b1; end
            if (acc[1]) begin m_sx[1] = u_if.req_xpos1; m_sy[1] = u_if.req_ypos1; m_pend[1] = 1'b1; end
            if (frame_edge) begin
                m_busy = 1'b1;
                m_e0   = cyc + 1;
            end
            m_prev = vblnk;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            check("xpos0",  32'(xpos0_out),    32'(m_x[0]));
            check("ypos0",  32'(ypos0_out),    32'(m_y[0]));
            check("xpos1",  32'(xpos1_out),    32'(m_x[1]));
            check("ypos1",  32'(ypos1_out),    32'(m_y[1]));
            check("pulse",  32'(commit_pulse), 32'(m_pulse));
            check("fcnt",   32'(frame_cnt),    32'(m_cnt));
            check("ready",  32'(u_if.req_ready), 32'(model_ready()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [11:0] x, input logic [11:0] y);
        if (i == 0) begin u_if.req_xpos0 = x; u_if.req_ypos0 = y; end
        else        begin u_if.req_xpos1 = x; u_if.req_ypos1 = y; end
        u_if.req_valid[i] = 1'b1;
        tick();
        u_if.req_valid[i] = 1'b0;
    endtask

    // Returns just after the edge has been sampled (scheduler in its first commit cycle)
    task automatic frame_start();
        vblnk = 1'b0;
        repeat (2) tick();
        vblnk = 1'b1;
        tick();
        vblnk = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0;
        u_if.req_valid = '0;
        u_if.req_xpos0 = '0; u_if.req_ypos0 = '0;
        u_if.req_xpos1 = '0; u_if.req_ypos1 = '0;

        // Reset then idle
        repeat (3) tick();
        check("rst_x0",    32'(xpos0_out), 32'd0);
        check("rst_fcnt",  32'(frame_cnt), 32'd0);
        check("rst_ready", 32'(u_if.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(u_if.req_ready), 32'd3);
        tick();

        // Single commit
        send(0, 12'd100, 12'd200);
        frame_start();
        tick();
        check("sc_x0",    32'(xpos0_out),    32'd100);
        check("sc_y0",    32'(ypos0_out),    32'd200);
        check("sc_pulse", 32'(commit_pulse), 32'd1);
        check("sc_x1",    32'(xpos1_out),    32'd0);
        tick();
        check("sc_fcnt",  32'(frame_cnt),    32'd1);

        // Clamp
        send(1, 12'd1000, 12'd4095);
        frame_start();
        tick();
        check("cl_pulse0", 32'(commit_pulse), 32'd0);
        tick();
        check("cl_x1",    32'(xpos1_out),    32'd799);
        check("cl_y1",    32'(ypos1_out),    32'd599);
        check("cl_pulse", 32'(commit_pulse), 32'd2);
        check("cl_fcnt",  32'(frame_cnt),    32'd2);

`ifdef LAST_WINS_EN
        // Newest data wins before the frame edge
        send(0, 12'd10, 12'd10);
        send(0, 12'd20, 12'd20);
        frame_start();
        tick();
        check("lw_x0", 32'(xpos0_out), 32'd20);
        tick();
        frame_start();
        tick();
        check("lw_nopulse", 32'(commit_pulse), 32'd0);
        tick();
        // Accept during the requester-0 commit cycle
        send(0, 12'd25, 12'd25);
        frame_start();
        u_if.req_xpos0 = 12'd30; u_if.req_ypos0 = 12'd30; u_if.req_valid[0] = 1'b1;
        tick();
        u_if.req_valid[0] = 1'b0;
        check("lw_old", 32'(xpos0_out), 32'd25);
        tick();
        frame_start();
        tick();
        check("lw_new", 32'(xpos0_out), 32'd30);
        tick();
`else
        // Backpressure: second update waits for the commit
        u_if.req_xpos0 = 12'd10; u_if.req_ypos0 = 12'd10; u_if.req_valid[0] = 1'b1;
        tick();
        u_if.req_xpos0 = 12'd20; u_if.req_ypos0 = 12'd20;
        check("bp_ready_lo", 32'(u_if.req_ready[0]), 32'd0);
        frame_start();
        check("bp_ready_c0", 32'(u_if.req_ready[0]), 32'd0);
        tick();
        check("bp_x0_first", 32'(xpos0_out), 32'd10);
        check("bp_ready_hi", 32'(u_if.req_ready[0]), 32'd1);
        tick();
        u_if.req_valid[0] = 1'b0;
        check("bp_ready_lo2", 32'(u_if.req_ready[0]), 32'd0);
        frame_start();
        tick();
        check("bp_x0_second", 32'(xpos0_out), 32'd20);
        tick();
`endif

        // Reset mid-sequence drops pending data
        send(0, 12'd50, 12'd60);
        frame_start();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_pulse", 32'(commit_pulse), 32'd0);
        check("mr_x0",    32'(xpos0_out),    32'd0);
        check("mr_fcnt",  32'(frame_cnt),    32'd0);
        frame_start();
        tick();
        check("mr_nocommit", 32'(commit_pulse), 32'd0);
        tick();
        check("mr_fcnt1", 32'(frame_cnt), 32'd1);

        // frame_cnt wrap: preload the counter, then complete one frame
        tick();
        force dut.r_frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        frame_start();
        repeat (2) tick();
        check("wrap", 32'(frame_cnt), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            u_if.req_valid = 2'($urandom_range(0, 3));
            u_if.req_xpos0 = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 1023));
            u_if.req_ypos0 = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 700));
            u_if.req_xpos1 = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 1023));
            u_if.req_ypos1 = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 700));
            if ($urandom_range(0, 3) == 0) vblnk = ~vblnk;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        u_if.req_valid = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
